// File: rtl/logic_unit_pkg.sv
// Shared encodings for the chunked logic unit: operation codes and FSM states.
// Optional feature macro used by the top level: CHUNKED_LOGIC_PARITY_EN.
package logic_unit_pkg;

  localparam int unsigned OP_W = 2;

  // Operation encodings
  localparam logic [OP_W-1:0] LOGIC_AND = 2'b00;
  localparam logic [OP_W-1:0] LOGIC_OR  = 2'b01;
  localparam logic [OP_W-1:0] LOGIC_XOR = 2'b10;
  localparam logic [OP_W-1:0] LOGIC_NOR = 2'b11;

  // FSM state encodings
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_RUN  = 2'd1;
  localparam logic [ST_W-1:0] S_DONE = 2'd2;

endpackage

// File: rtl/chunk_logic_slice.sv
// Combinational CHUNK-bit logic slice shared by every chunk of an operation.
module chunk_logic_slice
  import logic_unit_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic [CHUNK-1:0] r
);

  // Select the bitwise function; NOR inverts within this chunk only
  always_comb begin
    r = '0;
    unique case (op)
      LOGIC_AND: r = x & y;
      LOGIC_OR:  r = x | y;
      LOGIC_XOR: r = x ^ y;
      LOGIC_NOR: r = ~(x | y);
      default:   r = '0;
    endcase
  end

endmodule

// File: rtl/chunked_logic_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, CHUNK bits
// per clock, least-significant chunk first, with start/busy/done handshake.
// Optional feature: define CHUNKED_LOGIC_PARITY_EN to add a registered parity
// output (XOR-reduction of the final result).
module chunked_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef CHUNKED_LOGIC_PARITY_EN
  output logic             parity,
`endif
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject illegal chunking at elaboration time
  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("chunked_logic_unit: CHUNK must be in 1..WIDTH");
  end
  if ((WIDTH % CHUNK) != 0) begin : g_bad_div
    $error("chunked_logic_unit: WIDTH must be a multiple of CHUNK");
  end

  logic [ST_W-1:0]  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic [CHUNK-1:0] slice_x, slice_y, slice_r;
  logic [WIDTH-1:0] merged;
  int unsigned      sh;
`ifdef CHUNKED_LOGIC_PARITY_EN
  logic             par_acc_q, par_acc_d;
  logic             parity_q, parity_d;
`endif

  chunk_logic_slice #(.CHUNK(CHUNK)) u_slice (
    .op (op_q),
    .x  (slice_x),
    .y  (slice_y),
    .r  (slice_r)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    zero_d   = zero_q;
`ifdef CHUNKED_LOGIC_PARITY_EN
    par_acc_d = par_acc_q;
    parity_d  = parity_q;
`endif

    sh      = 32'(idx_q) * CHUNK;
    slice_x = CHUNK'(a_q >> sh);
    slice_y = CHUNK'(b_q >> sh);
    merged  = (result_q & ~(CHUNK_MASK << sh)) | (WIDTH'(slice_r) << sh);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          result_d = '0;
          idx_d    = '0;
          zero_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
`ifdef CHUNKED_LOGIC_PARITY_EN
          par_acc_d = 1'b0;
          parity_d  = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d = merged;
`ifdef CHUNKED_LOGIC_PARITY_EN
        par_acc_d = par_acc_q ^ (^slice_r);
`endif
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          zero_d  = (merged == '0);
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef CHUNKED_LOGIC_PARITY_EN
          parity_d = par_acc_d;
`endif
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and flag registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef CHUNKED_LOGIC_PARITY_EN
      par_acc_q <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
`ifdef CHUNKED_LOGIC_PARITY_EN
      par_acc_q <= par_acc_d;
      parity_q  <= parity_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
`ifdef CHUNKED_LOGIC_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_chunked_logic_unit.sv
// Self-checking bench for chunked_logic_unit (default 32/4 and a 16/16 instance).
module tb_chunked_logic_unit;
  import logic_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero;
  logic [31:0] result;

  logic        start16;
  logic [1:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, done16, zero16;
  logic [15:0] result16;
`ifdef CHUNKED_LOGIC_PARITY_EN
  logic        parity, parity16;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chunked_logic_unit #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
`ifdef CHUNKED_LOGIC_PARITY_EN
    .parity (parity),
`endif
    .zero   (zero)
  );

  chunked_logic_unit #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk    (clk),
    .reset  (reset),
    .start  (start16),
    .op     (op16),
    .a      (a16),
    .b      (b16),
    .busy   (busy16),
    .done   (done16),
    .result (result16),
`ifdef CHUNKED_LOGIC_PARITY_EN
    .parity (parity16),
`endif
    .zero   (zero16)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and wait for done; lat = edges after the accepting edge
  task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int cnt;
    vecs[0] = '{LOGIC_XOR, 32'hF0F0_1234, 32'h0F0F_FFFF, 32'hFFFF_EDCB, 1'b0};
    vecs[1] = '{LOGIC_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vecs[2] = '{LOGIC_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{LOGIC_OR,  32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0};
    vecs[4] = '{LOGIC_NOR, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{LOGIC_XOR, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[6] = '{LOGIC_AND, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'hDEAD_0000, 1'b0};
    vecs[7] = '{LOGIC_OR,  32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", result,      32'd0);
    check("reset_zero",   32'(zero),   32'd0);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
`ifdef CHUNKED_LOGIC_PARITY_EN
      check($sformatf("v%0d_parity", i), 32'(parity), 32'(^vecs[i].exp_result));
`endif
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_result_hold", i), result, vecs[i].exp_result);
    end

    // Chunk-by-chunk progression of the XOR example
    @(negedge clk);
    start = 1'b1; op = LOGIC_XOR; a = 32'hF0F0_1234; b = 32'h0F0F_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("prog_e0", result, 32'h0000_0000);
    @(negedge clk);
    check("prog_e1", result, 32'h0000_000B);
    @(negedge clk);
    check("prog_e2", result, 32'h0000_00CB);
    repeat (8) @(negedge clk);

    // Reset in the middle of RUN abandons the op
    @(negedge clk);
    start = 1'b1; op = LOGIC_XOR; a = 32'hF0F0_1234; b = 32'h0F0F_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_result", result,    32'd0);
    check("midrst_zero",   32'(zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("midrst_no_done", 32'(cnt), 32'd0);
    run_op(LOGIC_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    check("midrst_next_lat", 32'(lat), 32'd8);
    check("midrst_next_res", result, 32'hF000_F000);

    // Operand and start changes during RUN are ignored
    @(negedge clk);
    start = 1'b1; op = LOGIC_NOR; a = 32'h0; b = 32'h0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = LOGIC_AND; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    lat = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        check("busyin_result", result, 32'hFFFF_FFFF);
        check("busyin_zero", 32'(zero), 32'd0);
      end
    end
    check("busyin_one_done", 32'(cnt), 32'd1);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    start = 1'b1; op = LOGIC_OR; a = 32'h1; b = 32'h2;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_res", result, 32'h3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted_busy", 32'(busy), 32'd1);
    cnt = 1;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_gap", 32'(cnt), 32'd9);
    check("b2b_second_res", result, 32'h3);

    // Single-chunk configuration
    @(negedge clk);
    start16 = 1'b1; op16 = LOGIC_XOR; a16 = 16'hFFFF; b16 = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    check("w16_busy", 32'(busy16), 32'd1);
    check("w16_done_early", 32'(done16), 32'd0);
    @(negedge clk);
    check("w16_done", 32'(done16), 32'd1);
    check("w16_result", 32'(result16), 32'h0000_FF00);
    check("w16_zero", 32'(zero16), 32'd0);
`ifdef CHUNKED_LOGIC_PARITY_EN
    check("w16_parity", 32'(parity16), 32'd0);
`endif
    @(negedge clk);
    check("w16_done_clear", 32'(done16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
